// File: rtl/exu_wbck.sv
// -----------------------------------------------------------------------------
// exu_wbck - writeback stage behind the execute calculation unit.
//
// ALU results are buffered in a small FIFO. Load results from the LSU are not
// buffered. The two sources share the single register-file write port through
// a registered output.
//
// The LSU always has priority. A starvation counter tracks how many LSU wins
// in a row have happened while the FIFO held data. When it reaches
// STARVE_MAX, the LSU is refused for one cycle so that the FIFO head drains.
//
// Parameters
//   FIFO_DEPTH  ALU result FIFO entries (power of two, >= 2)
//   STARVE_MAX  consecutive LSU wins over a non-empty FIFO (>= 1)
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   hs_cal4wb_val  ALU result valid
//   hs_wb4cal_rdy  FIFO can accept an ALU result (registered state only)
//   cal_res/cal_rd ALU result data / destination register
//   hs_lsu4wb_val  load result valid
//   hs_wb4lsu_rdy  load result accepted this cycle (registered state only)
//   lsu_res/lsu_rd load data / destination register
//   wb_wen         register-file write enable
//   wb_rd/wb_data  register-file write index / data
//   fifo_cnt       current FIFO occupancy
// -----------------------------------------------------------------------------
module exu_wbck #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hs_cal4wb_val,
  output logic                          hs_wb4cal_rdy,
  input  logic [31:0]                   cal_res,
  input  logic [4:0]                    cal_rd,
  input  logic                          hs_lsu4wb_val,
  output logic                          hs_wb4lsu_rdy,
  input  logic [31:0]                   lsu_res,
  input  logic [4:0]                    lsu_rd,
  output logic                          wb_wen,
  output logic [4:0]                    wb_rd,
  output logic [31:0]                   wb_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;
  logic [STV_W-1:0] starve_cnt;

  logic      fifo_empty;
  logic      push;
  logic      pick_lsu;
  logic      pick_cal;
  wb_entry_t sel;

  assign fifo_empty = (cnt == '0);
  assign fifo_cnt   = cnt;

  // Both ready signals are derived only from registered state. This means
  // neither upstream unit sees a combinational path from its own valid.
  assign hs_wb4cal_rdy = (cnt != CNT_W'(FIFO_DEPTH));
  assign hs_wb4lsu_rdy = (starve_cnt != STV_W'(STARVE_MAX));

  assign push     = hs_cal4wb_val & hs_wb4cal_rdy;
  assign pick_lsu = hs_lsu4wb_val & hs_wb4lsu_rdy;
  assign pick_cal = !pick_lsu & !fifo_empty;

  // Selected write source: the LSU when it wins, otherwise the FIFO head.
  always_comb begin
    // NOTE: default first so every path assigns sel and no latch is inferred.
    sel = mem[rptr];
    if (pick_lsu) begin
      sel = '{rd: lsu_rd, data: lsu_res};
    end
  end

  // FIFO storage.
  // NOTE: the data array is deliberately not reset. Occupancy is tracked by
  // the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= '{rd: cal_rd, data: cal_res};
    end
  end

  // FIFO pointers and occupancy. A full FIFO refuses a push even when it
  // pops in the same cycle. Pointers wrap naturally because the depth is a
  // power of two.
  // NOTE: sequential state uses non-blocking assignments only, so all
  // registers sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pick_cal) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({push, pick_cal})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Starvation counter: counts LSU wins taken while ALU results were waiting.
  // Once the FIFO pops, waiting ALU results are no longer starved, so the
  // counter clears. The counter can only be at STARVE_MAX while the FIFO is
  // non-empty. In that cycle the LSU is refused, so pick_cal always clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (pick_cal) begin
      starve_cnt <= '0;
    end else if (pick_lsu && !fifo_empty) begin
      starve_cnt <= starve_cnt + STV_W'(1);
    end
  end

  // Registered write port. A result for x0 is consumed but never written.
  // The index and data hold when nothing is picked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_wen  <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_wen <= (pick_lsu | pick_cal) & (sel.rd != 5'd0);
      if (pick_lsu | pick_cal) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
    end
  end

endmodule

// File: tb/tb_exu_wbck.sv
// -----------------------------------------------------------------------------
// tb_exu_wbck - self-checking bench for exu_wbck.
//
// The bench keeps a behavioural reference model: a queue of pending ALU
// results, a count of LSU wins over waiting ALU results, and the last
// register-file write. The model advances once per clock alongside the DUT.
//
// Directed tasks compare against hand-derived constants. The random task
// compares every cycle against the model.
// -----------------------------------------------------------------------------
module tb_exu_wbck;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned STARVE_MAX = 4;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             hs_cal4wb_val;
  logic             hs_wb4cal_rdy;
  logic [31:0]      cal_res;
  logic [4:0]       cal_rd;
  logic             hs_lsu4wb_val;
  logic             hs_wb4lsu_rdy;
  logic [31:0]      lsu_res;
  logic [4:0]       lsu_rd;
  logic             wb_wen;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [CNT_W-1:0] fifo_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exu_wbck #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .hs_cal4wb_val(hs_cal4wb_val),
    .hs_wb4cal_rdy(hs_wb4cal_rdy),
    .cal_res      (cal_res),
    .cal_rd       (cal_rd),
    .hs_lsu4wb_val(hs_lsu4wb_val),
    .hs_wb4lsu_rdy(hs_wb4lsu_rdy),
    .lsu_res      (lsu_res),
    .lsu_rd       (lsu_rd),
    .wb_wen       (wb_wen),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .fifo_cnt     (fifo_cnt)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      q[$];
  int          starve;
  logic        m_wen;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  function automatic bit m_cal_rdy();
    return q.size() < int'(FIFO_DEPTH);
  endfunction

  function automatic bit m_lsu_rdy();
    return starve < int'(STARVE_MAX);
  endfunction

  task automatic model_reset();
    q.delete();
    starve = 0;
    m_wen  = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic idle_inputs();
    hs_cal4wb_val = 1'b0;
    cal_res       = '0;
    cal_rd        = '0;
    hs_lsu4wb_val = 1'b0;
    lsu_res       = '0;
    lsu_rd        = '0;
  endtask

  // Advance the model using the inputs presented this cycle.
  // Then step the DUT one clock and return 1 time unit after the edge.
  task automatic cycle();
    bit     push;
    bit     lsu_win;
    bit     cal_win;
    entry_t e;
    push    = hs_cal4wb_val && (q.size() < int'(FIFO_DEPTH));
    lsu_win = hs_lsu4wb_val && (starve < int'(STARVE_MAX));
    cal_win = !lsu_win && (q.size() != 0);
    if (lsu_win) begin
      m_wen  = (lsu_rd != 5'd0);
      m_rd   = lsu_rd;
      m_data = lsu_res;
      if (q.size() != 0) starve++;
    end else if (cal_win) begin
      e      = q.pop_front();
      m_wen  = (e.rd != 5'd0);
      m_rd   = e.rd;
      m_data = e.data;
      starve = 0;
    end else begin
      m_wen = 1'b0;
    end
    if (push) begin
      e.rd   = cal_rd;
      e.data = cal_res;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    model_reset();
    #2;
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen: got %0b want 0", wb_wen); end
    n_cmp++; if (wb_rd !== 5'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", wb_rd); end
    n_cmp++; if (wb_data !== 32'd0) begin n_err++; $display("FAIL reset_data: got %h want 0", wb_data); end
    n_cmp++; if (fifo_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt); end
    n_cmp++; if (hs_wb4cal_rdy !== 1'b1) begin n_err++; $display("FAIL reset_cal_rdy: got %0b want 1", hs_wb4cal_rdy); end
    n_cmp++; if (hs_wb4lsu_rdy !== 1'b1) begin n_err++; $display("FAIL reset_lsu_rdy: got %0b want 1", hs_wb4lsu_rdy); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_single_alu();
    hs_cal4wb_val = 1'b1;
    cal_rd        = 5'd5;
    cal_res       = 32'hDEAD_BEEF;
    n_cmp++; if (hs_wb4cal_rdy !== 1'b1) begin n_err++; $display("FAIL single_rdy: got %0b want 1", hs_wb4cal_rdy); end
    cycle();  // accepted in cycle 0
    idle_inputs();
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL single_c1_wen: got %0b want 0", wb_wen); end
    n_cmp++; if (fifo_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL single_c1_cnt: got %0d want 1", fifo_cnt); end
    cycle();
    n_cmp++; if (wb_wen !== 1'b1) begin n_err++; $display("FAIL single_c2_wen: got %0b want 1", wb_wen); end
    n_cmp++; if (wb_rd !== 5'd5) begin n_err++; $display("FAIL single_c2_rd: got %0d want 5", wb_rd); end
    n_cmp++; if (wb_data !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL single_c2_data: got %h want deadbeef", wb_data); end
    n_cmp++; if (fifo_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL single_c2_cnt: got %0d want 0", fifo_cnt); end
    cycle();
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL single_c3_wen: got %0b want 0", wb_wen); end
  endtask

  task automatic test_x0();
    // An ALU result for x0 is accepted and drained, but never written.
    hs_cal4wb_val = 1'b1;
    cal_rd        = 5'd0;
    cal_res       = 32'h1234;
    n_cmp++; if (hs_wb4cal_rdy !== 1'b1) begin n_err++; $display("FAIL x0_rdy: got %0b want 1", hs_wb4cal_rdy); end
    cycle();
    idle_inputs();
    n_cmp++; if (fifo_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL x0_cnt1: got %0d want 1", fifo_cnt); end
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL x0_c1_wen: got %0b want 0", wb_wen); end
    cycle();
    n_cmp++; if (fifo_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL x0_cnt0: got %0d want 0", fifo_cnt); end
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL x0_c2_wen: got %0b want 0", wb_wen); end
    cycle();
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL x0_c3_wen: got %0b want 0", wb_wen); end
    // A load for x0 is accepted, but not written.
    hs_lsu4wb_val = 1'b1;
    lsu_rd        = 5'd0;
    lsu_res       = 32'h5555;
    n_cmp++; if (hs_wb4lsu_rdy !== 1'b1) begin n_err++; $display("FAIL x0_lsu_rdy: got %0b want 1", hs_wb4lsu_rdy); end
    cycle();
    idle_inputs();
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL x0_lsu_wen: got %0b want 0", wb_wen); end
  endtask

  task automatic test_priority_full();
    hs_lsu4wb_val = 1'b1;
    lsu_rd        = 5'd7;
    lsu_res       = 32'h11;
    hs_cal4wb_val = 1'b1;
    cal_rd        = 5'd1;
    cal_res       = 32'hA1;
    cycle();
    cal_rd  = 5'd2;
    cal_res = 32'hA2;
    cycle();
    hs_cal4wb_val = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (fifo_cnt !== CNT_W'(2)) begin n_err++; $display("FAIL prio_cnt[%0d]: got %0d want 2", i, fifo_cnt); end
      n_cmp++; if (hs_wb4cal_rdy !== 1'b0) begin n_err++; $display("FAIL prio_full_rdy[%0d]: got %0b want 0", i, hs_wb4cal_rdy); end
      n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'h11) begin
        n_err++; $display("FAIL prio_lsu_wr[%0d]: got wen=%0b rd=%0d data=%h want 1/7/11", i, wb_wen, wb_rd, wb_data);
      end
      if (i < 2) cycle();
    end
    // LSU drops. A push attempted while full must be refused despite the pop.
    hs_lsu4wb_val = 1'b0;
    hs_cal4wb_val = 1'b1;
    cal_rd        = 5'd9;
    cal_res       = 32'h99;
    cycle();
    hs_cal4wb_val = 1'b0;
    n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'd1 || wb_data !== 32'hA1) begin
      n_err++; $display("FAIL prio_first_pop: got wen=%0b rd=%0d data=%h want 1/1/a1", wb_wen, wb_rd, wb_data);
    end
    n_cmp++; if (fifo_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL prio_no_push_when_full: got cnt %0d want 1", fifo_cnt); end
    n_cmp++; if (hs_wb4cal_rdy !== 1'b1) begin n_err++; $display("FAIL prio_rdy_back: got %0b want 1", hs_wb4cal_rdy); end
    cycle();
    n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'd2 || wb_data !== 32'hA2) begin
      n_err++; $display("FAIL prio_second_pop: got wen=%0b rd=%0d data=%h want 1/2/a2", wb_wen, wb_rd, wb_data);
    end
    cycle();
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL prio_done_wen: got %0b want 0", wb_wen); end
  endtask

  task automatic test_wrap();
    for (int c = 0; c < 13; c++) begin
      if (c < 10) begin
        hs_cal4wb_val = 1'b1;
        cal_rd        = 5'(c + 1);
        cal_res       = 32'((c + 1) * 3);
      end else begin
        idle_inputs();
      end
      n_cmp++; if (hs_wb4cal_rdy !== 1'b1) begin n_err++; $display("FAIL wrap_rdy[%0d]: got %0b want 1", c, hs_wb4cal_rdy); end
      n_cmp++; if (fifo_cnt > CNT_W'(1)) begin n_err++; $display("FAIL wrap_cnt[%0d]: got %0d want <=1", c, fifo_cnt); end
      cycle();
      // Now in cycle c+1. The write of entry rd=k is expected in cycle k+1.
      if (c >= 1 && c <= 10) begin
        n_cmp++; if (wb_wen !== 1'b1 || wb_rd !== 5'(c) || wb_data !== 32'(c * 3)) begin
          n_err++; $display("FAIL wrap_wr[%0d]: got wen=%0b rd=%0d data=%0d want 1/%0d/%0d", c, wb_wen, wb_rd, wb_data, c, c * 3);
        end
      end else begin
        n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL wrap_idle[%0d]: got wen %0b want 0", c, wb_wen); end
      end
    end
  endtask

  task automatic test_starvation();
    int last_low = -1;
    int lows     = 0;
    for (int c = 0; c < 22; c++) begin
      hs_cal4wb_val = 1'b1;
      cal_rd        = 5'(8 + c % 16);
      cal_res       = 32'hC000_0000 + 32'(c);
      hs_lsu4wb_val = 1'b1;
      lsu_rd        = 5'd7;
      lsu_res       = 32'h100 + 32'(c);
      n_cmp++; if (hs_wb4lsu_rdy !== m_lsu_rdy()) begin n_err++; $display("FAIL starve_rdy[%0d]: got %0b want %0b", c, hs_wb4lsu_rdy, m_lsu_rdy()); end
      if (hs_wb4lsu_rdy === 1'b0) begin
        if (last_low >= 0) begin
          n_cmp++; if (c - last_low != int'(STARVE_MAX) + 1) begin n_err++; $display("FAIL starve_period: got %0d want %0d", c - last_low, STARVE_MAX + 1); end
        end
        last_low = c;
        lows++;
      end
      cycle();
      n_cmp++; if (wb_wen !== m_wen || wb_rd !== m_rd || wb_data !== m_data) begin
        n_err++; $display("FAIL starve_wr[%0d]: got %0b/%0d/%h want %0b/%0d/%h", c, wb_wen, wb_rd, wb_data, m_wen, m_rd, m_data);
      end
      if (lows > 0 && c == last_low) begin
        n_cmp++; if (wb_wen !== 1'b1 || wb_rd === 5'd7) begin n_err++; $display("FAIL starve_alu_slot[%0d]: got wen=%0b rd=%0d want ALU write", c, wb_wen, wb_rd); end
      end
    end
    n_cmp++; if (lows != 4) begin n_err++; $display("FAIL starve_lows: got %0d want 4", lows); end
    idle_inputs();
    for (int i = 0; i < 4; i++) cycle();
    n_cmp++; if (fifo_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL starve_drain_cnt: got %0d want 0", fifo_cnt); end
  endtask

  task automatic test_reset_midstream();
    hs_lsu4wb_val = 1'b1;
    lsu_rd        = 5'd7;
    lsu_res       = 32'h77;
    hs_cal4wb_val = 1'b1;
    cal_rd        = 5'd3;
    cal_res       = 32'h33;
    cycle();
    cal_rd  = 5'd4;
    cal_res = 32'h44;
    cycle();
    idle_inputs();
    n_cmp++; if (fifo_cnt !== CNT_W'(2) || wb_wen !== 1'b1) begin n_err++; $display("FAIL mid_setup: got cnt=%0d wen=%0b want 2/1", fifo_cnt, wb_wen); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    n_cmp++; if (wb_wen !== 1'b0) begin n_err++; $display("FAIL mid_rst_wen: got %0b want 0", wb_wen); end
    n_cmp++; if (fifo_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL mid_rst_cnt: got %0d want 0", fifo_cnt); end
    n_cmp++; if (hs_wb4cal_rdy !== 1'b1) begin n_err++; $display("FAIL mid_rst_rdy: got %0b want 1", hs_wb4cal_rdy); end
    n_cmp++; if (wb_rd !== 5'd0 || wb_data !== 32'd0) begin n_err++; $display("FAIL mid_rst_out: got rd=%0d data=%h want 0/0", wb_rd, wb_data); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      n_cmp++; if (wb_wen !== 1'b0 || fifo_cnt !== CNT_W'(0)) begin
        n_err++; $display("FAIL mid_after[%0d]: got wen=%0b cnt=%0d want 0/0", i, wb_wen, fifo_cnt);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      hs_cal4wb_val = ($urandom_range(0, 9) < 7);
      cal_rd        = 5'($urandom_range(0, 31));
      cal_res       = $urandom();
      hs_lsu4wb_val = ($urandom_range(0, 9) < 6);
      lsu_rd        = 5'($urandom_range(0, 31));
      lsu_res       = $urandom();
      n_cmp++; if (hs_wb4cal_rdy !== m_cal_rdy() || hs_wb4lsu_rdy !== m_lsu_rdy()) begin
        n_err++; $display("FAIL rnd_rdy[%0d]: got cal=%0b lsu=%0b want cal=%0b lsu=%0b", c, hs_wb4cal_rdy, hs_wb4lsu_rdy, m_cal_rdy(), m_lsu_rdy());
      end
      cycle();
      n_cmp++; if (wb_wen !== m_wen || wb_rd !== m_rd || wb_data !== m_data) begin
        n_err++; $display("FAIL rnd_wr[%0d]: got %0b/%0d/%h want %0b/%0d/%h", c, wb_wen, wb_rd, wb_data, m_wen, m_rd, m_data);
      end
      n_cmp++; if (fifo_cnt !== CNT_W'(q.size())) begin n_err++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, fifo_cnt, q.size()); end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_alu();
    test_x0();
    test_priority_full();
    test_wrap();
    test_starvation();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
